// File: rtl/axis_bram_seq_ctrl.sv
// Command sequencer for the AXIS<->BRAM adapter: accepts one transfer command, pulses
// the adapter's address reload, then counts stream beats to report completion.
module axis_bram_seq_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int BEATS_PER_WORD = 36,
    parameter int CNT_WIDTH      = 18
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0] cmd_start_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_bound_addr,
    input  logic                  abort,
    output logic                  rw,
    output logic                  addr_reload,
    output logic [ADDR_WIDTH-1:0] bram_start_addr,
    output logic [ADDR_WIDTH-1:0] bram_bound_addr,
    input  logic                  mon_s_tvalid,
    input  logic                  mon_s_tready,
    input  logic                  mon_s_tlast,
    input  logic                  mon_m_tvalid,
    input  logic                  mon_m_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_short,
    output logic                  err_cmd,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_start;
    logic [ADDR_WIDTH-1:0] r_bound;
    logic [CNT_WIDTH-1:0]  r_total;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_short;

    logic                  w_hs;
    logic                  w_badCmd;
    logic [CNT_WIDTH-1:0]  w_countNext;
    logic [CNT_WIDTH-1:0]  w_words;
    logic [CNT_WIDTH-1:0]  w_total;
    logic                  w_lastBeat;
    logic                  w_shortExit;

    // Only the stream that matches the transfer direction is counted.
    assign w_hs        = r_rw ? (mon_s_tvalid && mon_s_tready) : (mon_m_tvalid && mon_m_tready);
    assign w_badCmd    = (r_bound < r_start);
    assign w_countNext = r_count + 1'b1;
    assign w_words     = CNT_WIDTH'(r_bound) - CNT_WIDTH'(r_start) + 1'b1;
    assign w_total     = w_words * CNT_WIDTH'(BEATS_PER_WORD);
    assign w_lastBeat  = (w_countNext == r_total);
    assign w_shortExit = r_rw && mon_s_tlast && !w_lastBeat;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over everything else, including a simultaneous final beat.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_next = S_CHECK;
            S_CHECK:  w_next = abort ? S_DONE : (w_badCmd ? S_IDLE : S_LOAD);
            S_LOAD:   w_next = abort ? S_DONE : S_SETTLE;
            S_SETTLE: w_next = abort ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort) begin
                    w_next = S_DONE;
                end else if (w_hs && (w_lastBeat || w_shortExit)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_rw    <= 1'b1;
            r_start <= '0;
            r_bound <= '0;
            r_total <= '0;
            r_count <= '0;
            r_short <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_rw    <= cmd_rw;
                        r_start <= cmd_start_addr;
                        r_bound <= cmd_bound_addr;
                    end
                end
                S_CHECK: begin
                    r_short <= 1'b0;
                    if (!w_badCmd) begin
                        r_total <= w_total;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    if (!abort && w_hs) begin
                        r_count <= w_countNext;
                        r_short <= w_shortExit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready       = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign addr_reload     = (r_state == S_LOAD);
    assign done            = (r_state == S_DONE);
    assign err_short       = (r_state == S_DONE) && r_short;
    assign err_cmd         = (r_state == S_CHECK) && w_badCmd && !abort;
    assign rw              = r_rw;
    assign bram_start_addr = r_start;
    assign bram_bound_addr = r_bound;
    assign beat_count      = r_count;

endmodule
